// File: rtl/conv3x3_pipe.sv
// conv3x3_pipe: pipelined 3x3 convolution with border masking, a runtime-loadable
// signed kernel, arithmetic right shift and saturation to an unsigned pixel.
// Stages: S1 masked products, S2 row sums, S3 total/round/shift/clamp (output regs).
// Optional feature macro: CONV3X3_ROUND_EN adds 2^(shift-1) before the shift
// (round half up); without it the shift truncates toward minus infinity.
module conv3x3_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEF_WIDTH  = 5,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [9*DATA_WIDTH-1:0]     window,
    input  logic [3:0]                  corner_type,
    input  logic                        coef_wr_en,
    input  logic [3:0]                  coef_wr_addr,
    input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
    input  logic [SHIFT_WIDTH-1:0]      shift_cfg,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic                        out_sat
);
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + 4;
    localparam int PROD_WIDTH = DATA_WIDTH + 1 + COEF_WIDTH;
    localparam int ROW_WIDTH  = PROD_WIDTH + 2;
    localparam logic signed [ACC_WIDTH-1:0] MAX_PIX = ACC_WIDTH'((1 << DATA_WIDTH) - 1);

    // Enabled taps per border case; bit k = tap k (row*3+col)
    function automatic logic [8:0] mask_of(input logic [3:0] corner);
        case (corner)
            4'd0:    mask_of = 9'b000_000_000;
            4'd1:    mask_of = 9'b000_011_011;
            4'd2:    mask_of = 9'b000_110_110;
            4'd3:    mask_of = 9'b011_011_011;
            4'd4:    mask_of = 9'b110_110_110;
            4'd5:    mask_of = 9'b011_011_000;
            4'd6:    mask_of = 9'b110_110_000;
            default: mask_of = 9'b111_111_111;
        endcase
    endfunction

    // Gaussian 1-2-1 kernel restored on reset
    function automatic logic signed [COEF_WIDTH-1:0] default_coef(input int k);
        case (k)
            4:          default_coef = COEF_WIDTH'(4);
            1, 3, 5, 7: default_coef = COEF_WIDTH'(2);
            default:    default_coef = COEF_WIDTH'(1);
        endcase
    endfunction

    logic signed [COEF_WIDTH-1:0] coef [9];
    logic                         adv;
    logic [8:0]                   tap_mask;
    logic signed [PROD_WIDTH-1:0] prod_comb [9];

    logic                         s1_valid;
    logic signed [PROD_WIDTH-1:0] s1_prod [9];
    logic [SHIFT_WIDTH-1:0]       s1_shift;

    logic                         s2_valid;
    logic signed [ROW_WIDTH-1:0]  s2_row [3];
    logic [SHIFT_WIDTH-1:0]       s2_shift;

    logic signed [ACC_WIDTH-1:0]  total;
    logic signed [ACC_WIDTH-1:0]  biased;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]        pix_next;
    logic                         sat_next;

    // Whole pipe advances together; a held output freezes every stage
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Kernel register file; a window accepted on the write edge sees the old value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) coef[k] <= default_coef(k);
        end else if (coef_wr_en && coef_wr_addr < 4'd9) begin
            coef[coef_wr_addr] <= coef_wr_data;
        end
    end

    // S1 input: zero-extended pixel times signed coefficient, masked taps forced to 0
    always_comb begin
        tap_mask = mask_of(corner_type);
        for (int k = 0; k < 9; k++) begin
            if (tap_mask[k])
                prod_comb[k] = PROD_WIDTH'($signed({1'b0, window[k*DATA_WIDTH +: DATA_WIDTH]}))
                             * PROD_WIDTH'(coef[k]);
            else
                prod_comb[k] = '0;
        end
    end

    // S3 input: total, optional rounding bias, arithmetic shift, clamp to pixel range
    always_comb begin
        total = ACC_WIDTH'(s2_row[0]) + ACC_WIDTH'(s2_row[1]) + ACC_WIDTH'(s2_row[2]);
`ifdef CONV3X3_ROUND_EN
        if (s2_shift != '0)
            biased = total + (ACC_WIDTH'(1) << (s2_shift - SHIFT_WIDTH'(1)));
        else
            biased = total;
`else
        biased = total;
`endif
        shifted = biased >>> s2_shift;
        if (shifted < 0) begin
            pix_next = '0;
            sat_next = 1'b1;
        end else if (shifted > MAX_PIX) begin
            pix_next = '1;
            sat_next = 1'b1;
        end else begin
            pix_next = shifted[DATA_WIDTH-1:0];
            sat_next = 1'b0;
        end
    end

    // Pipeline registers; reset drops every in-flight window
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            for (int k = 0; k < 9; k++) s1_prod[k] <= prod_comb[k];
            s1_shift <= shift_cfg;

            s2_valid <= s1_valid;
            for (int r = 0; r < 3; r++)
                s2_row[r] <= ROW_WIDTH'(s1_prod[3*r]) + ROW_WIDTH'(s1_prod[3*r+1])
                           + ROW_WIDTH'(s1_prod[3*r+2]);
            s2_shift <= s1_shift;

            out_valid <= s2_valid;
            data_out  <= pix_next;
            out_sat   <= sat_next;
        end
    end
endmodule

// File: tb/tb_conv3x3_pipe.sv
// Scoreboard bench for conv3x3_pipe: expectations are computed from a plain
// integer model of the filter when a window is accepted, and checked in order
// when the DUT hands a result downstream.
module tb_conv3x3_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [71:0] window = '0;
    logic [3:0]  corner_type = '0;
    logic        coef_wr_en = 1'b0;
    logic [3:0]  coef_wr_addr = '0;
    logic signed [4:0] coef_wr_data = '0;
    logic [3:0]  shift_cfg = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  data_out;
    logic        out_sat;

    conv3x3_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .window(window), .corner_type(corner_type), .coef_wr_en(coef_wr_en),
        .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
        .shift_cfg(shift_cfg), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] pix; logic sat; } exp_t;
    exp_t exp_q[$];
    int   mcoef [9];
    int   n_checks = 0;
    int   n_fail = 0;

    int   rdy_mode = 0;     // 0 always ready, 1 random, 2 held low
    bit   stall_arm = 1'b0;
    int   stall_left = 0;

    bit         prev_stall = 1'b0;
    logic [7:0] prev_pix;
    logic       prev_sat;

    function automatic void model_defaults();
        for (int k = 0; k < 9; k++)
            mcoef[k] = (k == 4) ? 4 : ((k % 2 == 1) ? 2 : 1);
    endfunction

    function automatic exp_t ref_model(input logic [71:0] w, input logic [3:0] c, input logic [3:0] s);
        exp_t e;
        int sum, d, q;
        bit en;
        sum = 0;
        for (int row = 0; row < 3; row++) begin
            for (int col = 0; col < 3; col++) begin
                case (c)
                    4'd0: en = 0;
                    4'd1: en = (row < 2) && (col < 2);
                    4'd2: en = (row < 2) && (col > 0);
                    4'd3: en = (col < 2);
                    4'd4: en = (col > 0);
                    4'd5: en = (row > 0) && (col < 2);
                    4'd6: en = (row > 0) && (col > 0);
                    default: en = 1;
                endcase
                if (en) sum += int'(w[(row*3+col)*8 +: 8]) * mcoef[row*3+col];
            end
        end
        d = 1 << s;
`ifdef CONV3X3_ROUND_EN
        if (s != 0) sum += d / 2;
`endif
        q = sum / d;
        if (sum < 0 && q * d != sum) q = q - 1;
        if (q < 0) begin e.pix = 8'd0; e.sat = 1'b1; end
        else if (q > 255) begin e.pix = 8'd255; e.sat = 1'b1; end
        else begin e.pix = 8'(q); e.sat = 1'b0; end
        return e;
    endfunction

    // out_ready driver
    always begin
        @(posedge clk);
        #1;
        if (stall_arm && out_valid) begin stall_left = 5; stall_arm = 1'b0; end
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard: signals are settled at the falling edge and describe
    // what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_defaults();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!out_valid || data_out !== prev_pix || out_sat !== prev_sat) begin
                    n_fail++;
                    $display("FAIL hold: got valid=%0b pix=%0d sat=%0b, need valid=1 pix=%0d sat=%0b",
                             out_valid, data_out, out_sat, prev_pix, prev_sat);
                end
            end
            if (out_valid && !out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_ready: got %0b need 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got pix=%0d sat=%0b, need no output", data_out, out_sat);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (data_out !== e.pix || out_sat !== e.sat) begin
                        n_fail++;
                        $display("FAIL result: got pix=%0d sat=%0b, need pix=%0d sat=%0b",
                                 data_out, out_sat, e.pix, e.sat);
                    end
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(window, corner_type, shift_cfg));
            if (coef_wr_en && coef_wr_addr < 4'd9)
                mcoef[coef_wr_addr] = int'(coef_wr_data);
            prev_stall = out_valid && !out_ready;
            prev_pix   = data_out;
            prev_sat   = out_sat;
        end
    end

    function automatic logic [71:0] flat(input int t [9]);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(t[k]);
        return w;
    endfunction

    function automatic logic [71:0] all_taps(input int v);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'(v);
        return w;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [71:0] w, input logic [3:0] c, input logic [3:0] s);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        window = w;
        corner_type = c;
        shift_cfg = s;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, need 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input logic [3:0] a, input int v);
        coef_wr_en = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = 5'(v);
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin @(posedge clk); #1; end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d results outstanding, need 0", exp_q.size());
        end
    endtask

    initial begin
        int lap [9];
        int taps [9];
        logic [71:0] w;

        model_defaults();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || data_out !== 8'd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%0b pix=%0d sat=%0b ready=%0b, need 0 0 0 1",
                     out_valid, data_out, out_sat, in_ready);
        end
        @(posedge clk);
        #1;

        // Default kernel, assorted border masks
        send(all_taps(100), 4'd7, 4'd4);
        send(all_taps(160), 4'd1, 4'd4);
        send(all_taps(160), 4'd0, 4'd4);
        for (int c = 2; c < 16; c++) send(all_taps(37 + 13 * c), 4'(c), 4'd4);
        drain();

        // Backpressure: 5 cycles low from the first out_valid
        stall_arm = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 9; k++) taps[k] = 10 * (i + 1) + (k % 8);
            send(flat(taps), 4'd7, 4'd4);
        end
        drain();

        // Laplacian
        lap = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
        for (int k = 0; k < 9; k++) write_coef(4'(k), lap[k]);
        taps = '{50, 50, 50, 50, 0, 50, 50, 50, 50};
        send(flat(taps), 4'd7, 4'd0);
        taps = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
        send(flat(taps), 4'd7, 4'd0);
        drain();

        // Rounding vs truncation, ignored addresses
        for (int k = 0; k < 9; k++) write_coef(4'(k), (k == 4) ? 1 : 0);
        write_coef(4'd9, 7);
        write_coef(4'd15, -3);
        taps = '{0, 0, 0, 0, 24, 0, 0, 0, 0};
        send(flat(taps), 4'd7, 4'd4);
        taps = '{0, 0, 0, 0, 40, 0, 0, 0, 0};
        send(flat(taps), 4'd7, 4'd4);
        drain();

        // Coefficient write on the same edge as an accepted window
        coef_wr_en = 1'b1;
        coef_wr_addr = 4'd4;
        coef_wr_data = 5'sd2;
        send(all_taps(16), 4'd7, 4'd4);
        coef_wr_en = 1'b0;
        send(all_taps(16), 4'd7, 4'd4);
        drain();

        // Random traffic with random readiness and coefficient writes
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                write_coef(4'($urandom_range(0, 15)), int'($urandom_range(0, 31)) - 16);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom);
            send(w, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        rdy_mode = 0;
        drain();

        // Reset with three windows in flight
        rdy_mode = 2;
        idle(1);
        send(all_taps(200), 4'd7, 4'd3);
        send(all_taps(201), 4'd7, 4'd3);
        send(all_taps(202), 4'd7, 4'd3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush: got out_valid=%0b, need 0", out_valid);
            end
        end
        @(posedge clk);
        #1;
        send(all_taps(100), 4'd7, 4'd4);
        send(all_taps(160), 4'd3, 4'd2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
